// File: rtl/hs_ad_pkg.sv
// rtl/hs_ad_pkg.sv - shared types and constants for the dual ADC capture sequencer
package hs_ad_pkg;

  localparam int AD_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;
  localparam logic SRC_CH0   = 1'b0;
  localparam logic SRC_CH1   = 1'b1;

  typedef struct packed {
    logic [AD_W-1:0] data;
    logic            otr;
  } ad_sample_t;

  // Counter width that never collapses to zero bits for tiny limits.
  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/hs_dual_ad_capture_ctrl_if.sv
// rtl/hs_dual_ad_capture_ctrl_if.sv - record RAM write port between sequencer and sample RAM
interface hs_dual_ad_capture_ctrl_if #(
  parameter int AW = 10
);
  import hs_ad_pkg::*;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [2*AD_W-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/hs_ad_trig_detect.sv
// rtl/hs_ad_trig_detect.sv - q/p sample pipeline for both channels and level-crossing compare
module hs_ad_trig_detect
  import hs_ad_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AD_W-1:0] ad0_data,
  input  logic            ad0_otr,
  input  logic [AD_W-1:0] ad1_data,
  input  logic            ad1_otr,
  input  logic            trig_src,
  input  logic            trig_edge,
  input  logic [AD_W-1:0] trig_level,
  output logic [AD_W-1:0] q0_data,
  output logic            q0_otr,
  output logic [AD_W-1:0] q1_data,
  output logic            q1_otr,
  output logic            trig_hit
);

  ad_sample_t      s0_q, s0_d, s1_q, s1_d;
  logic [AD_W-1:0] p0_q, p0_d, p1_q, p1_d;
  logic [AD_W-1:0] sel_q, sel_p;
  logic            rise_hit, fall_hit;

  always_comb begin
    s0_d = '{data: ad0_data, otr: ad0_otr};
    s1_d = '{data: ad1_data, otr: ad1_otr};
    p0_d = s0_q.data;
    p1_d = s1_q.data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
      p0_q <= '0;
      p1_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      p0_q <= p0_d;
      p1_q <= p1_d;
    end
  end

  always_comb begin
    sel_q    = (trig_src == SRC_CH1) ? s1_q.data : s0_q.data;
    sel_p    = (trig_src == SRC_CH1) ? p1_q : p0_q;
    rise_hit = (sel_p < trig_level) && (sel_q >= trig_level);
    fall_hit = (sel_p > trig_level) && (sel_q <= trig_level);
    trig_hit = (trig_edge == EDGE_FALL) ? fall_hit : rise_hit;
  end

  assign q0_data = s0_q.data;
  assign q0_otr  = s0_q.otr;
  assign q1_data = s1_q.data;
  assign q1_otr  = s1_q.otr;

endmodule

// File: rtl/hs_dual_ad_capture_ctrl.sv
// rtl/hs_dual_ad_capture_ctrl.sv - capture sequencer: arm, trigger, fixed-length record write, status
module hs_dual_ad_capture_ctrl
  import hs_ad_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic [AD_W-1:0]                  ad0_data,
  input  logic                             ad0_otr,
  input  logic [AD_W-1:0]                  ad1_data,
  input  logic                             ad1_otr,
  input  logic                             arm,
  input  logic                             abort,
  input  logic                             force_trig,
  input  logic                             auto_mode,
  input  logic                             trig_src,
  input  logic                             trig_edge,
  input  logic [AD_W-1:0]                  trig_level,
  hs_dual_ad_capture_ctrl_if.master        wr,
  output logic                             busy,
  output logic                             done,
  output logic                             rec_valid,
  output logic                             auto_trig,
  output logic                             otr0_flag,
  output logic                             otr1_flag
);

  localparam int            TW        = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  logic [AD_W-1:0] q0_data, q1_data;
  logic            q0_otr, q1_otr, trig_hit;

  hs_ad_trig_detect u_trig (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .ad0_data   (ad0_data),
    .ad0_otr    (ad0_otr),
    .ad1_data   (ad1_data),
    .ad1_otr    (ad1_otr),
    .trig_src   (trig_src),
    .trig_edge  (trig_edge),
    .trig_level (trig_level),
    .q0_data    (q0_data),
    .q0_otr     (q0_otr),
    .q1_data    (q1_data),
    .q1_otr     (q1_otr),
    .trig_hit   (trig_hit)
  );

  state_t            state_q, state_d;
  logic [1:0]        hold_q, hold_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [2*AD_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        wr_otr_q, wr_otr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rec_valid_q, rec_valid_d;
  logic              auto_trig_q, auto_trig_d;
  logic              otr0_q, otr0_d;
  logic              otr1_q, otr1_d;
  logic              auto_hit;

  assign auto_hit = auto_mode && (tmo_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    tmo_d       = tmo_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_otr_d    = wr_otr_q;
    done_d      = 1'b0;
    rec_valid_d = rec_valid_q;
    auto_trig_d = auto_trig_q;
    otr0_d      = otr0_q;
    otr1_d      = otr1_q;

    // The out-of-range bits travel with the write they belong to.
    if (state_q == ST_CAPTURE && wr_en_q) begin
      otr0_d = otr0_q | wr_otr_q[0];
      otr1_d = otr1_q | wr_otr_q[1];
    end

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d     = ST_ARMED;
          hold_d      = 2'd2;
          rec_valid_d = 1'b0;
          auto_trig_d = 1'b0;
          otr0_d      = 1'b0;
          otr1_d      = 1'b0;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 2'd1;
          if (hold_q == 2'd1) begin
            state_d = ST_WAIT_TRIG;
            tmo_d   = '0;
          end
        end
      end
      ST_WAIT_TRIG: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (trig_hit || force_trig || auto_hit) begin
          state_d     = ST_CAPTURE;
          wr_en_d     = 1'b1;
          wr_addr_d   = '0;
          wr_data_d   = {q1_data, q0_data};
          wr_otr_d    = {q1_otr, q0_otr};
          auto_trig_d = !trig_hit && !force_trig;
        end else if (tmo_q != TO_LAST) begin
          tmo_d = tmo_q + TO_ONE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wr_addr_q == LAST_ADDR) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          rec_valid_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_ONE;
          wr_data_d = {q1_data, q0_data};
          wr_otr_d  = {q1_otr, q0_otr};
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ARMED) || (state_d == ST_WAIT_TRIG) || (state_d == ST_CAPTURE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_otr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rec_valid_q <= 1'b0;
      auto_trig_q <= 1'b0;
      otr0_q      <= 1'b0;
      otr1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_otr_q    <= wr_otr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rec_valid_q <= rec_valid_d;
      auto_trig_q <= auto_trig_d;
      otr0_q      <= otr0_d;
      otr1_q      <= otr1_d;
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rec_valid  = rec_valid_q;
  assign auto_trig  = auto_trig_q;
  assign otr0_flag  = otr0_q;
  assign otr1_flag  = otr1_q;

endmodule

// File: tb/tb_hs_dual_ad_capture_ctrl.sv
// tb/tb_hs_dual_ad_capture_ctrl.sv - self-checking bench for hs_dual_ad_capture_ctrl
module tb_hs_dual_ad_capture_ctrl;

  localparam int DEPTH   = 64;
  localparam int AW      = 6;
  localparam int TIMEOUT = 16;
  localparam int MAXC    = 200;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [9:0] ad0_data = '0, ad1_data = '0, trig_level = '0;
  logic       ad0_otr = 1'b0, ad1_otr = 1'b0;
  logic       arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
  logic       auto_mode = 1'b0, trig_src = 1'b0, trig_edge = 1'b0;
  logic       busy, done, rec_valid, auto_trig, otr0_flag, otr1_flag;

  int pass_cnt = 0;
  int total_cnt = 0;

  hs_dual_ad_capture_ctrl_if #(.AW(AW)) wr_if ();

  hs_dual_ad_capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .ad0_data   (ad0_data),
    .ad0_otr    (ad0_otr),
    .ad1_data   (ad1_data),
    .ad1_otr    (ad1_otr),
    .arm        (arm),
    .abort      (abort),
    .force_trig (force_trig),
    .auto_mode  (auto_mode),
    .trig_src   (trig_src),
    .trig_edge  (trig_edge),
    .trig_level (trig_level),
    .wr         (wr_if),
    .busy       (busy),
    .done       (done),
    .rec_valid  (rec_valid),
    .auto_trig  (auto_trig),
    .otr0_flag  (otr0_flag),
    .otr1_flag  (otr1_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Edge i below means the rising edge on which the inputs of slot i are sampled; arm is slot 0.
  task automatic run_record(input string name, input int kind, input logic src, input logic edg,
                            input int lvl, input logic amode, input int force_at, input int abort_at,
                            input int arm2_at, input int otr0_at, input int otr1_at,
                            output int first_edge, output logic [19:0] first_data);
    int s0[MAXC];
    int s1[MAXC];
    bit o0[MAXC];
    bit o1[MAXC];
    bit frc[MAXC];
    int obs_edge[$];
    int obs_addr[$];
    logic [19:0] obs_data[$];
    int done_edge[$];
    int n, m, lim, last, n_exp, p, q;
    bit lvl_hit, auto_exp, done_exp, f0, f1;
    logic [19:0] exp_data;

    trig_src = src; trig_edge = edg; trig_level = lvl[9:0]; auto_mode = amode;
    n = 0;
    for (int i = 0; i < MAXC; i++) begin
      case (kind)
        0: begin s0[i] = (500 + 5 * ((i < 2) ? 0 : i - 2)) % 1024; s1[i] = int'($urandom_range(0, 1023)); end
        1: begin
          s0[i] = int'($urandom_range(0, 1023));
          s1[i] = (i <= 2) ? 110 : (i == 3) ? 101 : (i == 4) ? 100 : 90;
        end
        2: begin s0[i] = 300; s1[i] = 100; end
        default: begin s0[i] = int'($urandom_range(0, 1023)); s1[i] = int'($urandom_range(0, 1023)); end
      endcase
      o0[i] = (i == otr0_at); o1[i] = (i == otr1_at); frc[i] = (i == force_at);
      ad0_data = s0[i][9:0]; ad1_data = s1[i][9:0];
      ad0_otr = o0[i]; ad1_otr = o1[i];
      arm = (i == 0) || (i == arm2_at);
      abort = (i == abort_at);
      force_trig = frc[i];
      tick();
      n = i + 1;
      if (i == 0) begin
        total_cnt++;
        if ({busy, rec_valid, auto_trig, otr0_flag, otr1_flag} !== 5'b10000)
          $display("FAIL %s arm_status: got %b expected 10000", name, {busy, rec_valid, auto_trig, otr0_flag, otr1_flag});
        else pass_cnt++;
      end
      if (wr_if.wr_en === 1'b1) begin
        obs_edge.push_back(i); obs_addr.push_back(int'(wr_if.wr_addr)); obs_data.push_back(wr_if.wr_data);
      end
      if (done === 1'b1) done_edge.push_back(i);
      if (done_edge.size() > 0 && i >= done_edge[0] + 2) break;
      if (abort_at >= 0 && i >= abort_at + 2) break;
    end
    arm = 0; abort = 0; force_trig = 0; ad0_otr = 0; ad1_otr = 0;

    // Reference: find the first waiting edge that satisfies a trigger rule.
    m = -1; auto_exp = 0;
    lim = (abort_at >= 0) ? abort_at : n;
    for (int e = 3; e < lim && e < n; e++) begin
      p = src ? s1[e-2] : s0[e-2];
      q = src ? s1[e-1] : s0[e-1];
      lvl_hit = edg ? (p > lvl && q <= lvl) : (p < lvl && q >= lvl);
      if (lvl_hit || frc[e] || (amode && (e - 3) == TIMEOUT - 1)) begin
        m = e; auto_exp = !lvl_hit && !frc[e];
        break;
      end
    end
    n_exp = 0; done_exp = 0; f0 = 0; f1 = 0;
    if (m >= 0) begin
      last = m + DEPTH - 1;
      if (abort_at >= 0 && abort_at - 1 < last) last = abort_at - 1;
      n_exp = last - m + 1;
      done_exp = (abort_at < 0) || (abort_at > m + DEPTH);
      for (int k = 0; k < n_exp; k++) begin f0 |= o0[m-1+k]; f1 |= o1[m-1+k]; end
    end

    total_cnt++;
    if (obs_edge.size() != n_exp) $display("FAIL %s write_count: got %0d expected %0d", name, obs_edge.size(), n_exp);
    else pass_cnt++;
    for (int k = 0; k < n_exp && k < obs_edge.size(); k++) begin
      exp_data = {s1[m-1+k][9:0], s0[m-1+k][9:0]};
      total_cnt++;
      if (obs_edge[k] != m + k || obs_addr[k] != k || obs_data[k] !== exp_data)
        $display("FAIL %s write[%0d]: got edge %0d addr %0d data %h expected edge %0d addr %0d data %h",
                 name, k, obs_edge[k], obs_addr[k], obs_data[k], m + k, k, exp_data);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_edge.size() != (done_exp ? 1 : 0))
      $display("FAIL %s done_count: got %0d expected %0d", name, done_edge.size(), done_exp ? 1 : 0);
    else if (done_exp && done_edge[0] != m + DEPTH)
      $display("FAIL %s done_edge: got %0d expected %0d", name, done_edge[0], m + DEPTH);
    else pass_cnt++;
    total_cnt++;
    if ({busy, rec_valid, auto_trig, otr0_flag, otr1_flag} !== {1'b0, done_exp, auto_exp && m >= 0, f0, f1})
      $display("FAIL %s final_status: got %b expected %b", name, {busy, rec_valid, auto_trig, otr0_flag, otr1_flag},
               {1'b0, done_exp, auto_exp && m >= 0, f0, f1});
    else pass_cnt++;

    first_edge = (obs_edge.size() > 0) ? obs_edge[0] : -1;
    first_data = (obs_data.size() > 0) ? obs_data[0] : 20'h0;
  endtask

  task automatic check_all_zero(input string name);
    total_cnt++;
    if ({wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, busy, done, rec_valid, auto_trig, otr0_flag, otr1_flag} !== '0)
      $display("FAIL %s: got wr_en %b addr %0d data %h status %b expected all zero", name, wr_if.wr_en, wr_if.wr_addr,
               wr_if.wr_data, {busy, done, rec_valid, auto_trig, otr0_flag, otr1_flag});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tick(); tick();
    check_all_zero("reset_held");
    sys_rst_n = 1'b1;
    tick(); tick();
    check_all_zero("reset_released");
  endtask

  task automatic test_rising_ramp();
    int fe; logic [19:0] fd;
    run_record("ramp", 0, 1'b0, 1'b0, 512, 1'b0, -1, -1, -1, -1, -1, fe, fd);
    total_cnt++;
    if (fe != 6 || fd[9:0] !== 10'd515) $display("FAIL ramp_first: got edge %0d ch0 %0d expected edge 6 ch0 515", fe, fd[9:0]);
    else pass_cnt++;
  endtask

  task automatic test_falling_ch1();
    int fe; logic [19:0] fd;
    run_record("fall", 1, 1'b1, 1'b1, 100, 1'b0, -1, -1, -1, -1, -1, fe, fd);
    total_cnt++;
    if (fd[19:10] !== 10'd100) $display("FAIL fall_first: got ch1 %0d expected 100", fd[19:10]);
    else pass_cnt++;
    run_record("flat", 2, 1'b1, 1'b1, 100, 1'b0, -1, 40, -1, -1, -1, fe, fd);
    total_cnt++;
    if (fe != -1) $display("FAIL flat_no_trig: got first write edge %0d expected none", fe);
    else pass_cnt++;
  endtask

  task automatic test_auto_and_force();
    int fe; logic [19:0] fd;
    run_record("auto", 2, 1'b0, 1'b0, 512, 1'b1, -1, -1, -1, -1, -1, fe, fd);
    total_cnt++;
    if (fe != 18 || auto_trig !== 1'b1) $display("FAIL auto_start: got edge %0d auto %b expected edge 18 auto 1", fe, auto_trig);
    else pass_cnt++;
    run_record("force", 2, 1'b0, 1'b0, 512, 1'b1, 7, -1, -1, -1, -1, fe, fd);
    total_cnt++;
    if (fe != 7 || auto_trig !== 1'b0) $display("FAIL force_start: got edge %0d auto %b expected edge 7 auto 0", fe, auto_trig);
    else pass_cnt++;
  endtask

  task automatic test_otr();
    int fe; logic [19:0] fd;
    run_record("otr", 2, 1'b0, 1'b0, 512, 1'b0, 20, -1, -1, 40, 8, fe, fd);
    total_cnt++;
    if ({otr0_flag, otr1_flag} !== 2'b10) $display("FAIL otr_flags: got %b expected 10", {otr0_flag, otr1_flag});
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int fe; logic [19:0] fd;
    run_record("abort", 2, 1'b0, 1'b0, 512, 1'b0, 5, 43, 20, -1, -1, fe, fd);
    total_cnt++;
    if (wr_if.wr_en !== 1'b0 || int'(wr_if.wr_addr) != 37 || rec_valid !== 1'b0)
      $display("FAIL abort_end: got wr_en %b addr %0d rec_valid %b expected 0 37 0", wr_if.wr_en, wr_if.wr_addr, rec_valid);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int fe; logic [19:0] fd;
    trig_src = 1'b0; trig_edge = 1'b0; trig_level = 10'd512; auto_mode = 1'b0; ad0_data = 10'd300;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 1; i < 20; i++) begin
      force_trig = (i == 5);
      tick();
    end
    force_trig = 1'b0;
    total_cnt++;
    if (wr_if.wr_en !== 1'b1) $display("FAIL rst_mid_capture: got wr_en %b expected 1", wr_if.wr_en);
    else pass_cnt++;
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();
    run_record("post_reset", 0, 1'b0, 1'b0, 512, 1'b0, -1, -1, -1, -1, -1, fe, fd);
    total_cnt++;
    if (fe != 6) $display("FAIL post_reset_first: got edge %0d expected 6", fe);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int fe; logic [19:0] fd;
    for (int r = 0; r < 3; r++) begin
      run_record("random", 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                 1'b0, 60, -1, -1, int'($urandom_range(10, 120)), int'($urandom_range(10, 120)), fe, fd);
    end
  endtask

  initial begin
    test_reset();
    test_rising_ramp();
    test_falling_ch1();
    test_auto_and_force();
    test_otr();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
